// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer: FSM states, statusreg layout, divider codes.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StRelease,
        StRespond
    } seq_state_e;

    localparam int unsigned StatWidth  = 6;
    localparam int unsigned StatOp     = 0;
    localparam int unsigned StatFbo    = 1;
    localparam int unsigned StatDivLsb = 2;
    localparam int unsigned StatDivMsb = 4;
    localparam int unsigned StatEn     = 5;

    // Codes 101..111 also select 1:16 on the master side.
    typedef enum logic [2:0] {
        Div1  = 3'b000,
        Div2  = 3'b001,
        Div4  = 3'b010,
        Div8  = 3'b011,
        Div16 = 3'b100
    } spi_div_e;

    function automatic logic [StatWidth-1:0] pack_status(input logic       en,
                                                         input logic [2:0] div,
                                                         input logic       fbo,
                                                         input logic       op);
        logic [StatWidth-1:0] s;
        s                        = '0;
        s[StatEn]                = en;
        s[StatDivMsb:StatDivLsb] = div;
        s[StatFbo]               = fbo;
        s[StatOp]                = op;
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full/empty need no counter.
module spi_cmd_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             spi_clk_i,
    input  logic             spi_rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wptr_q;
    logic [AddrW:0]   rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

    always_ff @(posedge spi_clk_i or negedge spi_rst_ni) begin
        if (!spi_rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + {{AddrW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rptr_q <= rptr_q + {{AddrW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge spi_clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Feeds buffered command bytes to the SPI master one transaction at a time and returns
// each 2-word reply (or a watchdog timeout) over a valid/ready port.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    spi_clk_i,
    input  logic                    spi_rst_ni,
    input  logic [DATA_WIDTH-1:0]   cmd_data_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cfg_fbo_i,
    input  logic [2:0]              cfg_div_i,
    input  logic                    cfg_enable_i,
    output logic [2*DATA_WIDTH-1:0] rsp_data_o,
    output logic                    rsp_timeout_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    busy_o,
    output logic [DATA_WIDTH-1:0]   spi_data_o,
    output logic [StatWidth-1:0]    spi_statusreg_o,
    input  logic                    spi_doneflag_i,
    input  logic [2*DATA_WIDTH-1:0] spi_rsp_data_i
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    seq_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   spi_data_q, spi_data_d;
    logic                    fbo_q, fbo_d;
    logic [2:0]              div_q, div_d;
    logic                    en_q, en_d;
    logic                    timed_out_q, timed_out_d;
    logic [WdW-1:0]          wdog_q, wdog_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    rsp_valid_q, rsp_valid_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic                    stat_op;
    logic                    stat_en;

    assign cmd_ready_o = !fifo_full;

    spi_cmd_fifo #(
        .Width (DATA_WIDTH),
        .Depth (FIFO_DEPTH)
    ) u_cmd_fifo (
        .spi_clk_i  (spi_clk_i),
        .spi_rst_ni (spi_rst_ni),
        .push_i     (cmd_valid_i && cmd_ready_o),
        .wdata_i    (cmd_data_i),
        .pop_i      (fifo_pop),
        .rdata_o    (fifo_rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        spi_data_d    = spi_data_q;
        fbo_d         = fbo_q;
        div_d         = div_q;
        en_d          = en_q;
        timed_out_d   = timed_out_q;
        wdog_d        = wdog_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_valid_d   = rsp_valid_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_enable_i && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    spi_data_d  = fifo_rdata;
                    fbo_d       = cfg_fbo_i;
                    div_d       = cfg_div_i;
                    en_d        = 1'b1;
                    timed_out_d = 1'b0;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
                wdog_d  = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // Done wins over a coinciding watchdog expiry.
                if (spi_doneflag_i) begin
                    state_d = StRelease;
                end else if (wdog_q == WdLast) begin
                    timed_out_d = 1'b1;
                    en_d        = 1'b0;
                    state_d     = StRelease;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            StRelease: begin
                rsp_data_d    = timed_out_q ? '1 : spi_rsp_data_i;
                rsp_timeout_d = timed_out_q;
                rsp_valid_d   = 1'b1;
                state_d       = StRespond;
            end
            StRespond: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge spi_clk_i or negedge spi_rst_ni) begin
        if (!spi_rst_ni) begin
            state_q       <= StIdle;
            spi_data_q    <= '0;
            fbo_q         <= 1'b0;
            div_q         <= '0;
            en_q          <= 1'b0;
            timed_out_q   <= 1'b0;
            wdog_q        <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            spi_data_q    <= spi_data_d;
            fbo_q         <= fbo_d;
            div_q         <= div_d;
            en_q          <= en_d;
            timed_out_q   <= timed_out_d;
            wdog_q        <= wdog_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    // Decoded from reset-cleared state so the operation bit drops with reset, not a clock later.
    always_comb begin
        stat_op         = (state_q == StLaunch) || (state_q == StWaitDone);
        stat_en         = (state_q == StIdle) ? (en_q && cfg_enable_i) : en_q;
        spi_statusreg_o = pack_status(stat_en, div_q, fbo_q, stat_op);
    end

    assign busy_o        = (state_q != StIdle);
    assign spi_data_o    = spi_data_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign rsp_valid_o   = rsp_valid_q;

endmodule
